// File: rtl/cv32e40x_clint_irq_ctrl.sv
// CLINT-mode interrupt controller: registers irq lines, builds mip, arbitrates by RISC-V priority.
// Optional `CV32E40X_IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of the irq register.
module cv32e40x_clint_irq_ctrl #(
  parameter logic [31:0] IRQ_VALID_MASK = 32'hFFFF_0888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_i,
  input  logic [31:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic        irq_ack_i,
  output logic        irq_req_ctrl_o,
  output logic [9:0]  irq_id_ctrl_o,
  output logic        irq_wu_ctrl_o,
  output logic [31:0] mip_o,
  output logic        irq_ack_o,
  output logic [4:0]  irq_id_o
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] REQ   = 2'b01;
  localparam logic [1:0] BLANK = 2'b10;

  logic [31:0] w_irq_src;
  logic [31:0] r_irq_q;
  logic [31:0] w_pending;
  logic        w_irq_en;
  logic [4:0]  w_best_id;
  logic [1:0]  r_state;
  logic [4:0]  r_id_q;
  logic        r_ack;
  logic [4:0]  r_id_o;

`ifdef CV32E40X_IRQ_SYNC_EN
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_src = r_sync2;
`else
  assign w_irq_src = irq_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_q <= '0;
    else        r_irq_q <= w_irq_src & IRQ_VALID_MASK;
  end

  assign w_pending = r_irq_q & mie_i & IRQ_VALID_MASK;
  assign w_irq_en  = mstatus_mie_i & (|w_pending);

  // Evaluated lowest priority first so later hits override: 7, 3, 11, then 16..31.
  always_comb begin
    w_best_id = '0;
    if (w_pending[7])  w_best_id = 5'd7;
    if (w_pending[3])  w_best_id = 5'd3;
    if (w_pending[11]) w_best_id = 5'd11;
    for (int unsigned i = 16; i < 32; i++) begin
      if (w_pending[i]) w_best_id = i[4:0];
    end
  end

  function automatic logic [4:0] prio_rank(input logic [4:0] id);
    case (id)
      5'd7:    prio_rank = 5'd1;
      5'd3:    prio_rank = 5'd2;
      5'd11:   prio_rank = 5'd3;
      default: prio_rank = id[4] ? id : 5'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_id_q  <= '0;
      r_ack   <= 1'b0;
      r_id_o  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_irq_en) begin
            r_id_q  <= w_best_id;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            r_state <= BLANK;
            r_ack   <= 1'b1;
            r_id_o  <= r_id_q;
          end else if (!w_irq_en) begin
            r_state <= IDLE;
          end else if (prio_rank(w_best_id) > prio_rank(r_id_q)) begin
            r_id_q <= w_best_id;
          end else if (!w_pending[r_id_q]) begin
            r_id_q <= w_best_id;
          end
        end
        BLANK:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_req_ctrl_o = (r_state == REQ);
  assign irq_id_ctrl_o  = {5'b0, r_id_q};
  assign irq_wu_ctrl_o  = |w_pending;
  assign mip_o          = r_irq_q;
  assign irq_ack_o      = r_ack;
  assign irq_id_o       = r_id_o;

endmodule

// File: tb/tb_cv32e40x_clint_irq_ctrl.sv
// Directed, table-driven bench for cv32e40x_clint_irq_ctrl.
module tb_cv32e40x_clint_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_i;
  logic [31:0] mie_i;
  logic        mstatus_mie_i;
  logic        irq_ack_i;
  logic        irq_req_ctrl_o;
  logic [9:0]  irq_id_ctrl_o;
  logic        irq_wu_ctrl_o;
  logic [31:0] mip_o;
  logic        irq_ack_o;
  logic [4:0]  irq_id_o;

  int tests = 0;
  int fails = 0;

  cv32e40x_clint_irq_ctrl #(.IRQ_VALID_MASK(32'hFFFF_0888)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq_i),
    .mie_i          (mie_i),
    .mstatus_mie_i  (mstatus_mie_i),
    .irq_ack_i      (irq_ack_i),
    .irq_req_ctrl_o (irq_req_ctrl_o),
    .irq_id_ctrl_o  (irq_id_ctrl_o),
    .irq_wu_ctrl_o  (irq_wu_ctrl_o),
    .mip_o          (mip_o),
    .irq_ack_o      (irq_ack_o),
    .irq_id_o       (irq_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] irq;
    logic [31:0] mie;
    logic        ms;
    logic        ack;
    logic [31:0] mip;
    logic        wu;
    logic        req;
    logic [4:0]  id;
    logic        ack_o;
    logic [4:0]  id_o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] irq, input logic [31:0] mie, input logic ms,
                     input logic ack, input logic [31:0] mip, input logic wu,
                     input logic req, input logic [4:0] id, input logic ack_o,
                     input logic [4:0] id_o);
    vec_t v;
    v.irq = irq; v.mie = mie; v.ms = ms; v.ack = ack;
    v.mip = mip; v.wu = wu; v.req = req; v.id = id; v.ack_o = ack_o; v.id_o = id_o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req"},   -1, {31'b0, irq_req_ctrl_o}, 32'h0);
    chk({tag, " id"},    -1, {22'b0, irq_id_ctrl_o},  32'h0);
    chk({tag, " wu"},    -1, {31'b0, irq_wu_ctrl_o},  32'h0);
    chk({tag, " mip"},   -1, mip_o,                   32'h0);
    chk({tag, " ack_o"}, -1, {31'b0, irq_ack_o},      32'h0);
    chk({tag, " id_o"},  -1, {27'b0, irq_id_o},       32'h0);
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    rst_n = 1'b0; irq_i = '0; mie_i = '0; mstatus_mie_i = 1'b0; irq_ack_i = 1'b0;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef CV32E40X_IRQ_SYNC_EN
    mie_i = ALL; mstatus_mie_i = 1'b1;
    irq_i = 32'h0001_0000;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("sync mip", c, mip_o, (c >= 3) ? 32'h0001_0000 : 32'h0);
      chk("sync req", c, {31'b0, irq_req_ctrl_o}, (c >= 4) ? 32'h1 : 32'h0);
    end
    chk("sync id", 4, {22'b0, irq_id_ctrl_o}, 32'd16);
`else
    //   irq           mie        ms ack  mip           wu req id  ack_o id_o
    add(32'h800,      32'h800,   1, 0,   32'h800,      1, 0,  0,  0,    0);
    add(32'h800,      32'h800,   1, 0,   32'h800,      1, 1,  11, 0,    0);
    add(32'h0,        32'h800,   1, 0,   32'h0,        0, 1,  11, 0,    0);
    add(32'h0,        32'h800,   1, 0,   32'h0,        0, 0,  0,  0,    0);
    add(32'h0010_0888, ALL,      1, 0,   32'h0010_0888, 1, 0, 0,  0,    0);
    add(32'h0010_0888, ALL,      1, 0,   32'h0010_0888, 1, 1, 20, 0,    0);
    add(32'h888,      ALL,       1, 0,   32'h888,      1, 1,  20, 0,    0);
    add(32'h888,      ALL,       1, 0,   32'h888,      1, 1,  11, 0,    0);
    add(32'h088,      ALL,       1, 0,   32'h088,      1, 1,  11, 0,    0);
    add(32'h088,      ALL,       1, 0,   32'h088,      1, 1,  3,  0,    0);
    add(32'h080,      ALL,       1, 0,   32'h080,      1, 1,  3,  0,    0);
    add(32'h080,      ALL,       1, 0,   32'h080,      1, 1,  7,  0,    0);
    add(32'h088,      ALL,       1, 0,   32'h088,      1, 1,  7,  0,    0);
    add(32'h088,      ALL,       1, 0,   32'h088,      1, 1,  3,  0,    0);
    add(32'h088,      ALL,       1, 0,   32'h088,      1, 1,  3,  0,    0);
    add(32'h0001_0000, ALL,      1, 0,   32'h0001_0000, 1, 1, 3,  0,    0);
    add(32'h0001_0000, ALL,      1, 0,   32'h0001_0000, 1, 1, 16, 0,    0);
    add(32'h0001_0000, ALL,      1, 1,   32'h0001_0000, 1, 0, 0,  1,    16);
    add(32'h0001_0000, ALL,      1, 0,   32'h0001_0000, 1, 0, 0,  0,    16);
    add(32'h0001_0000, ALL,      1, 0,   32'h0001_0000, 1, 1, 16, 0,    16);
    add(32'h0,        ALL,       1, 0,   32'h0,        0, 1,  16, 0,    16);
    add(32'h0,        ALL,       1, 1,   32'h0,        0, 0,  0,  1,    16);
    add(32'h0,        ALL,       1, 0,   32'h0,        0, 0,  0,  0,    16);
    add(32'h0,        ALL,       1, 1,   32'h0,        0, 0,  0,  0,    16);
    add(32'h080,      32'h080,   0, 0,   32'h080,      1, 0,  0,  0,    16);
    add(32'h080,      32'h080,   0, 0,   32'h080,      1, 0,  0,  0,    16);
    add(ALL,          ALL,       0, 0,   32'hFFFF_0888, 1, 0, 0,  0,    16);
    add(ALL,          ALL,       1, 0,   32'hFFFF_0888, 1, 1, 31, 0,    16);

    foreach (vecs[i]) begin
      irq_i = vecs[i].irq; mie_i = vecs[i].mie;
      mstatus_mie_i = vecs[i].ms; irq_ack_i = vecs[i].ack;
      @(posedge clk); #1;
      chk("mip",   i, mip_o,                    vecs[i].mip);
      chk("wu",    i, {31'b0, irq_wu_ctrl_o},   {31'b0, vecs[i].wu});
      chk("req",   i, {31'b0, irq_req_ctrl_o},  {31'b0, vecs[i].req});
      if (vecs[i].req)
        chk("id", i, {22'b0, irq_id_ctrl_o}, {27'b0, vecs[i].id});
      chk("ack_o", i, {31'b0, irq_ack_o},       {31'b0, vecs[i].ack_o});
      chk("id_o",  i, {27'b0, irq_id_o},        {27'b0, vecs[i].id_o});
    end
    irq_ack_i = 1'b0;
`endif

    // Asynchronous reset between clock edges while a request is presented.
    #2;
    chk("pre-reset req", -1, {31'b0, irq_req_ctrl_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(posedge clk); #1;
    chk("reset hold ack_o", -1, {31'b0, irq_ack_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

endmodule
